// File: rtl/key_code_reader.sv
// Consumer end of the button-encoder link: synchronizes and debounces the key code and press flag,
// accepts one key per physical press, and packs accepted codes into a word for the game logic.
module key_code_reader #(
    parameter int unsigned WORD_LEN        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s0,
    input  logic                             s1,
    input  logic                             press,
    output logic                             buf_clear,
    output logic                             key_valid,
    output logic [1:0]                       key_code,
    output logic                             key_dropped,
    output logic [2*WORD_LEN-1:0]            word,
    output logic [$clog2(WORD_LEN+1)-1:0]    word_count,
    output logic                             word_valid,
    input  logic                             word_ack
);

    localparam int unsigned WcW = $clog2(WORD_LEN + 1);
    localparam int unsigned WW  = 2 * WORD_LEN;

    typedef enum logic [1:0] {StIdle, StDebounce, StCapture, StRelease} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_meta_q, press_s;
    logic [1:0]       code_meta_q, code_s;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_meta_q <= 1'b0;
            press_s      <= 1'b0;
            code_meta_q  <= 2'b00;
            code_s       <= 2'b00;
        end else begin
            press_meta_q <= press;
            press_s      <= press_meta_q;
            code_meta_q  <= {s1, s0};
            code_s       <= code_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (press_s) begin
                    cand_d  = code_s;
                    cnt_d   = '0;
                    state_d = StDebounce;
                end
            end
            StDebounce: begin
                // A code change restarts the stability window with the new candidate.
                if (!press_s) begin
                    state_d = StIdle;
                end else if (code_s != cand_q) begin
                    cand_d = code_s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: state_d = StRelease;
            StRelease: begin
                if (!press_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept     = (state_q == StDebounce) && (state_d == StCapture);
    assign word_valid = (word_count == WcW'(WORD_LEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cand_q      <= 2'b00;
            cnt_q       <= '0;
            buf_clear   <= 1'b0;
            key_valid   <= 1'b0;
            key_code    <= 2'b00;
            key_dropped <= 1'b0;
            word        <= '0;
            word_count  <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            buf_clear   <= (state_d == StRelease);
            key_valid   <= accept;
            key_dropped <= accept && !word_ack && word_valid;
            if (accept) key_code <= cand_q;
            // Acknowledge clears first, so a coincident key lands in an empty word.
            if (word_ack) begin
                word       <= accept ? WW'(cand_q) : '0;
                word_count <= accept ? WcW'(1) : '0;
            end else if (accept && !word_valid) begin
                word       <= {word[WW-3:0], cand_q};
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_code_reader.sv
// Randomized bench for key_code_reader against a run-length/queue reference model.
module tb_key_code_reader;

    localparam int WL = 4;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s0 = 1'b0, s1 = 1'b0, press = 1'b0, word_ack = 1'b0;
    logic       buf_clear, key_valid, key_dropped, word_valid;
    logic [1:0] key_code;
    logic [2*WL-1:0] word;
    logic [$clog2(WL+1)-1:0] word_count;

    key_code_reader #(.WORD_LEN(WL), .DEBOUNCE_CYCLES(DC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .s0(s0), .s1(s1), .press(press),
        .buf_clear(buf_clear), .key_valid(key_valid), .key_code(key_code),
        .key_dropped(key_dropped), .word(word), .word_count(word_count),
        .word_valid(word_valid), .word_ack(word_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_keys   = 0;

    // Reference model: synchronizer delay line, stable-run length, release holdoff, code queue.
    bit       m_p1, m_p2;
    bit [1:0] m_c1, m_c2;
    int       run;
    bit [1:0] run_code;
    bit       cap_pending, releasing;
    bit       e_bc, e_kv, e_kd;
    bit [1:0] e_kc;
    bit [1:0] q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_c1 = 0; m_c2 = 0;
        run = 0; run_code = 0; cap_pending = 0; releasing = 0;
        e_bc = 0; e_kv = 0; e_kd = 0; e_kc = 0;
        q.delete();
    endtask

    function automatic logic [2*WL-1:0] model_word();
        logic [2*WL-1:0] w = '0;
        foreach (q[i]) w = (w << 2) | (2*WL)'(q[i]);
        return w;
    endfunction

    task automatic model_step(input bit p, input bit [1:0] c, input bit a);
        bit acc = 0;
        e_kv = 0;
        e_kd = 0;
        if (cap_pending) begin
            cap_pending = 0;
            releasing   = 1;
            e_bc        = 1;
        end else if (releasing) begin
            if (!m_p2) begin
                releasing = 0;
                e_bc      = 0;
            end
        end else begin
            if (!m_p2) run = 0;
            else if (run > 0 && m_c2 == run_code) run++;
            else begin
                run      = 1;
                run_code = m_c2;
            end
            if (run == DC + 1) begin
                acc         = 1;
                run         = 0;
                cap_pending = 1;
            end
        end
        if (a) q.delete();
        if (acc) begin
            e_kv = 1;
            e_kc = run_code;
            n_keys++;
            if (q.size() < WL) q.push_back(run_code);
            else e_kd = 1;
        end
        m_p2 = m_p1; m_p1 = p;
        m_c2 = m_c1; m_c1 = c;
    endtask

    task automatic compare_all();
        check("buf_clear", buf_clear, e_bc);
        check("key_valid", key_valid, e_kv);
        check("key_code", key_code, e_kc);
        check("key_dropped", key_dropped, e_kd);
        check("word", word, model_word());
        check("word_count", word_count, q.size());
        check("word_valid", word_valid, q.size() == WL);
    endtask

    // Inputs change just after a falling edge; outputs are compared on the next falling edge.
    task automatic tick(input bit p, input bit [1:0] c, input bit a);
        press = p; {s1, s0} = c; word_ack = a;
        @(posedge clk);
        model_step(p, c, a);
        @(negedge clk);
        compare_all();
    endtask

    task automatic press_key(input bit [1:0] c, input int hold, input int gap, input int ack_at);
        for (int i = 0; i < hold; i++) tick(1, c, i == ack_at);
        for (int i = 0; i < gap; i++) tick(0, c, 0);
    endtask

    initial begin
        int k0;
        model_reset();
        #12;
        check("reset_buf_clear", buf_clear, 0);
        check("reset_word", word, 0);
        check("reset_count", word_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single key with code 2 held 20 cycles
        press_key(2'd2, 20, 6, -1);
        check("first_word", word, 8'h02);
        // Sequence 0..3, then an overflow key, then acknowledge
        for (int k = 0; k < 4; k++) press_key(2'(k), 8, 5, -1);
        tick(0, 0, 1);
        for (int k = 0; k < 4; k++) press_key(2'(k), 8, 5, -1);
        check("full_word", word, 8'h1B);
        press_key(2'd1, 8, 5, -1);
        check("full_word_kept", word, 8'h1B);
        tick(0, 0, 1);
        // Short glitch and mid-debounce code change
        press_key(2'd3, 3, 6, -1);
        tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
        press_key(2'd3, 10, 6, -1);
        // Fill word, then acknowledge on the capture edge of code 2
        for (int k = 0; k < 4; k++) press_key(2'(k), 8, 5, -1);
        press_key(2'd2, 10, 6, DC + 2);
        check("ack_capture_word", word, 8'h02);

        // Reset while releasing with press still held
        for (int i = 0; i < 10; i++) tick(1, 2'd1, 0);
        check("in_release", buf_clear, 1);
        #2 reset = 1'b1;
        #1;
        check("async_buf_clear", buf_clear, 0);
        check("async_word", word, 0);
        check("async_count", word_count, 0);
        check("async_key_valid", key_valid, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        k0 = n_keys;
        for (int i = 0; i < 15; i++) tick(1, 2'd1, 0);
        check("one_key_after_reset", n_keys - k0, 1);
        press_key(2'd1, 0, 6, -1);

        // Randomized presses with optional code change and sporadic acknowledges
        for (int it = 0; it < 300; it++) begin
            bit [1:0] c = 2'($urandom_range(0, 3));
            int h1 = $urandom_range(1, 10);
            int h2 = $urandom_range(0, 6);
            for (int i = 0; i < h1; i++) tick(1, c, $urandom_range(0, 11) == 0);
            c = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : c;
            for (int i = 0; i < h2; i++) tick(1, c, $urandom_range(0, 11) == 0);
            for (int i = $urandom_range(0, 6); i > 0; i--) tick(0, c, $urandom_range(0, 11) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
